ssd_scan_driver: RTL
====================

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of scanned digits; legal 2..8.
REQ-002 Parameter SLOT_DIV, default 1024, clk cycles per digit slot; SHALL be a multiple of 16, at least 16.
REQ-003 Parameter BLINK_FRAMES, default 64, frames per blink half-period; at least 1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 digits_in  in  4*NUM_DIGITS  digit codes, digit k at [4k+3:4k], digit 0 least significant.
REQ-007 dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-008 load  in  1  one-cycle strobe capturing digits_in/dp_in.
REQ-009 blank_lz  in  1  leading-zero blanking enable.
REQ-010 blink_mask  in  NUM_DIGITS  1 = digit blinks.
REQ-011 brightness  in  4  duty level 0..15.
REQ-012 ssd_enables  out  NUM_DIGITS  active-low one-hot anode enables.
REQ-013 ssd_segments  out  7  active-low segments {a,b,c,d,e,f,g}, bit 6 = a.
REQ-014 ssd_dp  out  1  active-low decimal point.
REQ-015 frame_done  out  1  one-cycle pulse per completed scan frame.

Function
REQ-016 Prescaler cnt SHALL count 0..SLOT_DIV-1 and wrap; slot_end when cnt = SLOT_DIV-1.
REQ-017 Digit index idx SHALL advance on slot_end, wrapping NUM_DIGITS-1 -> 0; frame boundary = slot_end with idx = NUM_DIGITS-1.
REQ-018 frame_done SHALL be 1 for exactly the cycle after each frame boundary.
REQ-019 load SHALL capture digits_in/dp_in into a stage register on that edge and set pending.
REQ-020 At a frame boundary with pending = 1, the shadow (displayed) register SHALL take stage and pending SHALL clear.
REQ-021 load coincident with a frame boundary: shadow takes previous stage, stage takes new data, pending stays 1.
REQ-022 Displayed data SHALL change only at frame boundaries; mid-frame loads SHALL NOT tear the display.
REQ-023 Decode: codes 0-9 -> digits (0 = 0000001, 1 = 1001111, 8 = 0000000, 9 = 0000100), 0xA -> minus 1111110, 0xB-0xF -> blank 1111111.
REQ-024 Leading-zero blanking: when blank_lz = 1, code-0 digits above the most significant non-zero code SHALL show blank with dp off; digit 0 SHALL never be blanked; 0xA counts as non-zero.
REQ-025 brightness SHALL be sampled at slot start (cnt = 0); enable for idx active only while cnt < (brightness+1)*(SLOT_DIV/16), all enables high otherwise.
REQ-026 Blink: frame counter SHALL toggle blink_phase every BLINK_FRAMES frame boundaries; when blink_phase = 1, digits with blink_mask set SHALL show segments 1111111 and dp off, enables still scanning.
REQ-027 All outputs SHALL be registered; outputs in cycle t+1 reflect cnt/idx/shadow in cycle t.
REQ-028 At most one ssd_enables bit SHALL be low in any cycle.

Reset
REQ-029 rst_n low SHALL immediately force cnt = 0, idx = 0, stage and shadow codes = 0xB, dp = 0, pending = 0, blink counter = 0, blink_phase = 0.
REQ-030 During reset: ssd_enables all 1, ssd_segments = 1111111, ssd_dp = 1, frame_done = 0.
REQ-031 Reset asserted mid-frame SHALL discard pending data; after release, the display is blank until a load commits at a frame boundary.

Verification (NUM_DIGITS=4, SLOT_DIV=16, BLINK_FRAMES=2)
REQ-032 Reset release, load digits_in=0x1234 -> after next frame boundary, enables cycle 1110,1101,1011,0111 every 16 cycles showing 4,3,2,1; frame_done every 64 cycles.
REQ-033 load 0x0057, blank_lz=1 -> digits 3,2 blank, digits 1,0 show 5,7; load 0x0000 -> only digit 0 shows 0.
REQ-034 brightness=3 -> enable low for 4 of 16 cycles per slot; brightness=15 -> low 16 of 16; change mid-slot takes effect next slot.
REQ-035 load 0x1111 mid-frame, then load 0x2222 on a frame-boundary cycle -> shadow 0x1111 that frame, 0x2222 after following boundary.
REQ-036 blink_mask=0001 -> digit 0 blank for 2 frames, lit for 2 frames, repeating; others steady.
REQ-037 rst_n low mid-slot with pending load -> outputs blank/off immediately; after release no digit lit until a new load commits.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver: time-slotted anode scanning with PWM
// brightness, frame-synchronous double-buffered data, leading-zero blanking and blink.
module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_DIV     = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   ssd_enables,
    output logic [6:0]              ssd_segments,
    output logic                    ssd_dp,
    output logic                    frame_done
);

    localparam int CW   = $clog2(SLOT_DIV);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP = SLOT_DIV / 16;

    localparam logic [4*NUM_DIGITS-1:0] BLANK_CODES = {NUM_DIGITS{4'hB}};

    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           idx_q;
    logic [4*NUM_DIGITS-1:0] stage_q;
    logic [NUM_DIGITS-1:0]   stageDp_q;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   shadowDp_q;
    logic                    pending_q;
    logic [BW-1:0]           blinkCnt_q;
    logic                    blinkPhase_q;
    logic [3:0]              bright_q;
    logic [NUM_DIGITS-1:0]   enables_q;
    logic [6:0]              segments_q;
    logic                    dp_q;
    logic                    frameDone_q;

    logic                  slotEnd;
    logic                  frameEnd;
    logic [3:0]            effBright;
    logic [CW:0]           thresh;
    logic [3:0]            curCode;
    logic                  curDp;
    logic                  curBlink;
    logic                  curLz;
    logic                  seenNz;
    logic [NUM_DIGITS-1:0] lzMask;
    logic [NUM_DIGITS-1:0] enables_d;
    logic [6:0]            segments_d;
    logic                  dp_d;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'b0000001;
            4'h1:    decode = 7'b1001111;
            4'h2:    decode = 7'b0010010;
            4'h3:    decode = 7'b0000110;
            4'h4:    decode = 7'b1001100;
            4'h5:    decode = 7'b0100100;
            4'h6:    decode = 7'b0100000;
            4'h7:    decode = 7'b0001111;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0000100;
            4'hA:    decode = 7'b1111110;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign slotEnd  = (cnt_q == CW'(SLOT_DIV - 1));
    assign frameEnd = slotEnd && (idx_q == IW'(NUM_DIGITS - 1));

    // Brightness is taken live on the first cycle of a slot and held for the rest of it.
    assign effBright = (cnt_q == '0) ? brightness : bright_q;
    assign thresh    = ((CW+1)'(effBright) + (CW+1)'(1)) * (CW+1)'(STEP);

    always_comb begin
        curCode  = 4'hB;
        curDp    = 1'b0;
        curBlink = 1'b0;
        curLz    = 1'b0;
        seenNz   = 1'b0;
        lzMask   = '0;
        // A digit is a leading zero when it and every digit above it hold code 0.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            seenNz    = seenNz | (shadow_q[4*k +: 4] != 4'h0);
            lzMask[k] = ~seenNz;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                curCode  = shadow_q[4*k +: 4];
                curDp    = shadowDp_q[k];
                curBlink = blink_mask[k];
                curLz    = lzMask[k];
            end
        end

        enables_d = '1;
        if ({1'b0, cnt_q} < thresh) begin
            enables_d[idx_q] = 1'b0;
        end

        segments_d = decode(curCode);
        dp_d       = ~curDp;
        if ((blank_lz && curLz) || (blinkPhase_q && curBlink)) begin
            segments_d = 7'b1111111;
            dp_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_q      <= BLANK_CODES;
            stageDp_q    <= '0;
            shadow_q     <= BLANK_CODES;
            shadowDp_q   <= '0;
            pending_q    <= 1'b0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
            bright_q     <= '0;
            enables_q    <= '1;
            segments_q   <= 7'b1111111;
            dp_q         <= 1'b1;
            frameDone_q  <= 1'b0;
        end else begin
            cnt_q <= slotEnd ? '0 : cnt_q + CW'(1);
            if (slotEnd) begin
                idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end
            if (cnt_q == '0) begin
                bright_q <= brightness;
            end

            // Commit uses the old stage, so a coincident load lands in stage and stays pending.
            if (frameEnd && pending_q) begin
                shadow_q   <= stage_q;
                shadowDp_q <= stageDp_q;
            end
            if (load) begin
                stage_q   <= digits_in;
                stageDp_q <= dp_in;
                pending_q <= 1'b1;
            end else if (frameEnd) begin
                pending_q <= 1'b0;
            end

            if (frameEnd) begin
                if (blinkCnt_q == BW'(BLINK_FRAMES - 1)) begin
                    blinkCnt_q   <= '0;
                    blinkPhase_q <= ~blinkPhase_q;
                end else begin
                    blinkCnt_q <= blinkCnt_q + BW'(1);
                end
            end

            enables_q   <= enables_d;
            segments_q  <= segments_d;
            dp_q        <= dp_d;
            frameDone_q <= frameEnd;
        end
    end

    assign ssd_enables  = enables_q;
    assign ssd_segments = segments_q;
    assign ssd_dp       = dp_q;
    assign frame_done   = frameDone_q;

endmodule
